// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: a two-slot elastic register (main + skid) feeding the register-file write port.
// Latency: 1 cycle from input transfer to out_valid; 1 instruction/cycle while out_ready is high.
// Backpressure: skid slot absorbs one extra beat; in_ready = !skid_valid, registered, no path from out_ready.
//
// Ports:
//   clk, rst (async active-high), flush (sync, drops both slots and any offered input)
//   in_valid/in_ready + ReadData, AluRes, Rd, RegWrite_in, MemToReg_in   : MEM-side handshake and payload
//   out_valid/out_ready + ReadData_out, AluRes_out, Rd_out, RegWrite_out, MemToReg_out, WbData : WB side
//   retired : count of output handshakes, wraps modulo 2^CNT_W
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] AluRes,
    input  logic [REG_W-1:0]  Rd,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ReadData_out,
    output logic [DATA_W-1:0] AluRes_out,
    output logic [REG_W-1:0]  Rd_out,
    output logic              RegWrite_out,
    output logic              MemToReg_out,
    output logic [DATA_W-1:0] WbData,
    output logic [CNT_W-1:0]  retired
);

    // Encoding is {main_valid, skid_valid}; (0,1) is never produced.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic load_m_in;   // main slot takes the incoming beat
    logic load_m_s;    // main slot takes the skid beat
    logic load_s_in;   // skid slot takes the incoming beat

    logic in_xfer, out_xfer, wen_in;

    logic [DATA_W-1:0] m_rdata, m_alu, s_rdata, s_alu;
    logic [REG_W-1:0]  m_rd, s_rd;
    logic              m_rw, m_m2r, s_rw, s_m2r;
    logic [CNT_W-1:0]  retired_q;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Writes to x0 are dropped at entry so nothing downstream has to re-check Rd.
    assign wen_in = RegWrite_in & (Rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s_in = 1'b0;
        if (flush) begin
            // Flush wins: no loads, so the offered beat is dropped.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        load_m_in = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_m_in = 1'b1;
                    end else if (in_xfer) begin
                        load_s_in = 1'b1;
                        state_d   = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        load_m_s = 1'b1;
                        state_d  = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Payload registers are not cleared by flush; valid bits alone qualify them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rdata <= '0;
            m_alu   <= '0;
            m_rd    <= '0;
            m_rw    <= 1'b0;
            m_m2r   <= 1'b0;
        end else if (load_m_in) begin
            m_rdata <= ReadData;
            m_alu   <= AluRes;
            m_rd    <= Rd;
            m_rw    <= wen_in;
            m_m2r   <= MemToReg_in;
        end else if (load_m_s) begin
            m_rdata <= s_rdata;
            m_alu   <= s_alu;
            m_rd    <= s_rd;
            m_rw    <= s_rw;
            m_m2r   <= s_m2r;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rdata <= '0;
            s_alu   <= '0;
            s_rd    <= '0;
            s_rw    <= 1'b0;
            s_m2r   <= 1'b0;
        end else if (load_s_in) begin
            s_rdata <= ReadData;
            s_alu   <= AluRes;
            s_rd    <= Rd;
            s_rw    <= wen_in;
            s_m2r   <= MemToReg_in;
        end
    end

    // A transfer completing in a flush cycle still reached the register file, so it counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           retired_q <= '0;
        else if (out_xfer) retired_q <= retired_q + CNT_W'(1);
    end

    assign ReadData_out = m_rdata;
    assign AluRes_out   = m_alu;
    assign Rd_out       = m_rd;
    assign MemToReg_out = m_m2r;
    assign RegWrite_out = m_rw & out_valid;
    assign WbData       = m_m2r ? m_rdata : m_alu;
    assign retired      = retired_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk, rst, flush;
    logic          in_valid, in_ready;
    logic [DW-1:0] ReadData, AluRes;
    logic [RW-1:0] Rd;
    logic          RegWrite_in, MemToReg_in;
    logic          out_valid, out_ready;
    logic [DW-1:0] ReadData_out, AluRes_out, WbData;
    logic [RW-1:0] Rd_out;
    logic          RegWrite_out, MemToReg_out;
    logic [CW-1:0] retired;

    mem_wb_pipe #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ReadData(ReadData), .AluRes(AluRes), .Rd(Rd),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ReadData_out(ReadData_out), .AluRes_out(AluRes_out), .Rd_out(Rd_out),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .WbData(WbData), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the stage behaves as a 2-deep FIFO of instructions.
    typedef struct packed {
        logic [DW-1:0] rdat;
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
        logic          rw;
        logic          m2r;
    } item_t;

    item_t q[$];
    int    cnt;
    int    total;
    int    bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        item_t h;
        chk({ph, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({ph, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
        chk({ph, ".retired"},   32'(retired),   32'(cnt % (1 << CW)));
        if (q.size() > 0) begin
            h = q[0];
            chk({ph, ".ReadData_out"}, ReadData_out, h.rdat);
            chk({ph, ".AluRes_out"},   AluRes_out,   h.alu);
            chk({ph, ".Rd_out"},       32'(Rd_out),  32'(h.rd));
            chk({ph, ".RegWrite_out"}, 32'(RegWrite_out), 32'(h.rw));
            chk({ph, ".MemToReg_out"}, 32'(MemToReg_out), 32'(h.m2r));
            chk({ph, ".WbData"},       WbData, h.m2r ? h.rdat : h.alu);
        end else begin
            chk({ph, ".RegWrite_out_idle"}, 32'(RegWrite_out), 32'd0);
        end
    endtask

    // One clock: drive, advance model on the edge, check #1 after it.
    task automatic cycle(input string ph, input logic v, input logic [DW-1:0] rdat, input logic [DW-1:0] alu,
                         input logic [RW-1:0] rd, input logic rw, input logic m2r,
                         input logic ordy, input logic fl, output logic acc);
        item_t it;
        logic  room, out_x;
        in_valid = v; ReadData = rdat; AluRes = alu; Rd = rd;
        RegWrite_in = rw; MemToReg_in = m2r; out_ready = ordy; flush = fl;
        room  = (q.size() < 2);
        out_x = (q.size() > 0) && ordy;
        acc   = v && room && !fl;
        it.rdat = rdat; it.alu = alu; it.rd = rd; it.m2r = m2r;
        it.rw   = rw && (rd != 0);
        @(posedge clk);
        if (out_x) begin
            void'(q.pop_front());
            cnt++;
        end
        if (fl)       q.delete();
        else if (acc) q.push_back(it);
        #1;
        check_outputs(ph);
    endtask

    task automatic idle(input string ph, input logic ordy);
        logic a;
        cycle(ph, 1'b0, '0, '0, '0, 1'b0, 1'b0, ordy, 1'b0, a);
    endtask

    initial begin
        logic acc;
        int   k;
        int   guard;
        total = 0; bad = 0; cnt = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ReadData = '0; AluRes = '0; Rd = '0; RegWrite_in = 1'b0; MemToReg_in = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.WbData",    WbData, 32'd0);
        chk("rst.retired",   32'(retired), 32'd0);
        chk("rst.RegWrite_out", 32'(RegWrite_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming with out_ready high
        for (int i = 0; i < 3; i++)
            cycle("stream", 1'b1, 32'hAAAA0000 + i, 32'h10 * (i + 1), RW'(i + 1), 1'b1, 1'b0, 1'b1, 1'b0, acc);
        idle("stream_tail", 1'b1);
        chk("stream.retired_total", 32'(retired), 32'd3);

        // Stall: 3 cycles of out_ready low while offering 1,2,3,4
        k = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, '0, DW'(k), 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        chk("stall.accepted", 32'(k - 1), 32'd2);
        chk("stall.in_ready_low", 32'(in_ready), 32'd0);
        guard = 0;
        while ((k <= 4 || q.size() > 0) && guard < 20) begin
            cycle("drain", k <= 4, '0, DW'(k), 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, acc);
            if (acc) k++;
            guard++;
        end
        chk("drain.bounded", 32'(guard < 20), 32'd1);
        chk("drain.empty", 32'(out_valid), 32'd0);

        // x0 write suppression
        cycle("x0", 1'b1, 32'h1, 32'h55, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        chk("x0.valid", 32'(out_valid), 32'd1);
        chk("x0.RegWrite_out", 32'(RegWrite_out), 32'd0);
        idle("x0_tail", 1'b1);

        // Write-back select
        cycle("wbsel", 1'b1, 32'hDEADBEEF, 32'h4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        chk("wbsel.WbData", WbData, 32'hDEADBEEF);
        chk("wbsel.RegWrite_out", 32'(RegWrite_out), 32'd1);
        idle("wbsel_tail", 1'b1);

        // Flush in FULL with an input offered
        cycle("fill", 1'b1, '0, 32'hA1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        cycle("fill", 1'b1, '0, 32'hA2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        chk("fill.full", 32'(in_ready), 32'd0);
        cycle("flush", 1'b1, '0, 32'hBAD, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, acc);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        chk("flush.RegWrite_out", 32'(RegWrite_out), 32'd0);
        chk("flush.in_ready", 32'(in_ready), 32'd1);
        idle("post_flush", 1'b1);
        idle("post_flush", 1'b1);

        // Asynchronous reset mid-cycle while FULL
        cycle("fill2", 1'b1, 32'h77, 32'hB1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, acc);
        cycle("fill2", 1'b1, 32'h88, 32'hB2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, acc);
        #3 rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        chk("arst.retired", 32'(retired), 32'd0);
        chk("arst.WbData", WbData, 32'd0);
        chk("arst.ReadData_out", ReadData_out, 32'd0);
        chk("arst.AluRes_out", AluRes_out, 32'd0);
        chk("arst.Rd_out", 32'(Rd_out), 32'd0);
        chk("arst.MemToReg_out", 32'(MemToReg_out), 32'd0);
        q.delete();
        cnt = 0;
        #2 rst = 1'b0;

        // Counter wrap: 17 transfers on a 4-bit counter
        for (int i = 0; i < 17; i++)
            cycle("wrap", 1'b1, $urandom(), $urandom(), RW'($urandom_range(31)), 1'b1,
                  1'($urandom_range(1)), 1'b1, 1'b0, acc);
        idle("wrap_tail", 1'b1);
        chk("wrap.retired", 32'(retired), 32'd1);

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 400; i++)
            cycle("rand", 1'($urandom_range(1)), $urandom(), $urandom(), RW'($urandom_range(31)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) != 0),
                  ($urandom_range(19) == 0), acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
